// File: rtl/input_matrix_scanner.sv
// Key-matrix scan initiator: strobes S or R rows, samples the mapped K
// response after a settle delay and commits an atomic 32-bit snapshot.
module input_matrix_scanner #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  cpu_id,
  input  logic        scan_start,
  output logic        scan_busy,
  output logic        scan_done,
  output logic [7:0]  scan_s,
  output logic [3:0]  scan_r,
  input  logic [3:0]  scan_k,
  input  logic        scan_beta,
  input  logic        scan_ba,
  input  logic        scan_acl,
  output logic [31:0] matrix,
  output logic [2:0]  flags
);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  localparam logic [3:0] SETTLE = 4'(SETTLE_CYCLES);

  state_t      state;
  state_t      state_nx;
  logic        sm5a;
  logic [2:0]  row;
  logic [3:0]  cnt;
  logic [31:0] shadow;
  logic [2:0]  shadow_f;
  logic        capture;
  logic        last_row;

  assign capture  = (state == SCAN) && (cnt == SETTLE);
  assign last_row = sm5a ? (row == 3'd2) : (row == 3'd7);
  assign scan_busy = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (scan_start) state_nx = SCAN;
      SCAN: if (capture && last_row) state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // SM5a has no R0 strobe, so its rows map to R1..R3
  always_comb begin
    scan_s = '0;
    scan_r = '0;
    if (state == SCAN) begin
      if (sm5a) begin
        scan_r = 4'b0010 << row[1:0];
      end else begin
        scan_s = 8'b0000_0001 << row;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sm5a      <= 1'b0;
      row       <= '0;
      cnt       <= '0;
      shadow    <= '0;
      shadow_f  <= '0;
      matrix    <= '0;
      flags     <= '0;
      scan_done <= 1'b0;
    end else begin
      scan_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (scan_start) begin
            sm5a     <= (cpu_id == 4'd4);
            shadow   <= '0;
            shadow_f <= '0;
            row      <= '0;
            cnt      <= '0;
          end
        end
        SCAN: begin
          if (capture) begin
            shadow[{row, 2'b00} +: 4] <= scan_k;
            cnt <= '0;
            if (last_row) begin
              shadow_f <= {scan_acl, scan_ba, scan_beta};
            end else begin
              row <= row + 3'd1;
            end
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        DONE: begin
          matrix    <= shadow;
          flags     <= shadow_f;
          scan_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_input_matrix_scanner.sv
// Directed bench for input_matrix_scanner: three instances cover the
// default settle time and the 1 and 15 extremes behind a K-mapping model.
module tb_input_matrix_scanner;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  cpu_id;
  logic [2:0]  start;
  logic        beta;
  logic        ba;
  logic        acl;
  logic [3:0]  k    [3];
  logic        busy [3];
  logic        done [3];
  logic [7:0]  s_o  [3];
  logic [3:0]  r_o  [3];
  logic [31:0] m_o  [3];
  logic [2:0]  f_o  [3];
  logic [3:0]  ks   [8];
  logic [3:0]  kr   [4];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  input_matrix_scanner #(.SETTLE_CYCLES(2)) u0 (
    .clk(clk), .reset(reset), .cpu_id(cpu_id),
    .scan_start(start[0]), .scan_busy(busy[0]),
    .scan_done(done[0]), .scan_s(s_o[0]), .scan_r(r_o[0]),
    .scan_k(k[0]), .scan_beta(beta), .scan_ba(ba),
    .scan_acl(acl), .matrix(m_o[0]), .flags(f_o[0])
  );

  input_matrix_scanner #(.SETTLE_CYCLES(1)) u1 (
    .clk(clk), .reset(reset), .cpu_id(cpu_id),
    .scan_start(start[1]), .scan_busy(busy[1]),
    .scan_done(done[1]), .scan_s(s_o[1]), .scan_r(r_o[1]),
    .scan_k(k[1]), .scan_beta(beta), .scan_ba(ba),
    .scan_acl(acl), .matrix(m_o[1]), .flags(f_o[1])
  );

  input_matrix_scanner #(.SETTLE_CYCLES(15)) u2 (
    .clk(clk), .reset(reset), .cpu_id(cpu_id),
    .scan_start(start[2]), .scan_busy(busy[2]),
    .scan_done(done[2]), .scan_s(s_o[2]), .scan_r(r_o[2]),
    .scan_k(k[2]), .scan_beta(beta), .scan_ba(ba),
    .scan_acl(acl), .matrix(m_o[2]), .flags(f_o[2])
  );

  function automatic logic [3:0] kf(input logic [7:0] s,
                                    input logic [3:0] r);
    logic [3:0] v;
    v = 4'h0;
    for (int i = 0; i < 8; i++) if (s[i]) v = ks[i];
    for (int i = 0; i < 4; i++) if (r[i]) v = kr[i];
    return v;
  endfunction

  // mapping block: one registered cycle from strobe to K
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) k[i] <= kf(s_o[i], r_o[i]);
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_scan(input int d);
    start[d] = 1'b1;
    @(posedge clk); #1;
    start[d] = 1'b0;
  endtask

  // entered 1 time unit after E0; returns 1 unit after the done edge
  task automatic body(input int d, input int n, input int s,
                      input logic [31:0] old_m,
                      input logic [31:0] exp_m,
                      input logic [2:0] exp_f, input bit pulse);
    int last;
    last = n * (s + 1);
    for (int t = 0; t <= last + 1; t++) begin
      logic [7:0] es;
      logic [3:0] er;
      int row;
      es = 8'h0;
      er = 4'h0;
      if (t < last) begin
        row = t / (s + 1);
        if (n == 3) er = 4'b0010 << row;
        else es = 8'b0000_0001 << row;
      end
      chk("scan_s", 32'(s_o[d]), 32'(es));
      chk("scan_r", 32'(r_o[d]), 32'(er));
      chk("scan_busy", 32'(busy[d]), 32'(t <= last));
      chk("scan_done", 32'(done[d]), 32'(t == last + 1));
      chk("matrix", m_o[d], (t == last + 1) ? exp_m : old_m);
      if (t == last + 1) chk("flags", 32'(f_o[d]), 32'(exp_f));
      if (pulse && t == 3) start[d] = 1'b1;
      if (pulse && t == 4) start[d] = 1'b0;
      if (t <= last) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic chk_zero();
    for (int d = 0; d < 3; d++) begin
      chk("rst_busy", 32'(busy[d]), 32'd0);
      chk("rst_done", 32'(done[d]), 32'd0);
      chk("rst_s", 32'(s_o[d]), 32'd0);
      chk("rst_r", 32'(r_o[d]), 32'd0);
      chk("rst_matrix", m_o[d], 32'd0);
      chk("rst_flags", 32'(f_o[d]), 32'd0);
    end
  endtask

  initial begin
    reset  = 1'b1;
    start  = 3'b000;
    cpu_id = 4'd0;
    beta   = 1'b0;
    ba     = 1'b0;
    acl    = 1'b0;
    for (int i = 0; i < 8; i++) ks[i] = 4'(i);
    kr[0] = 4'h0;
    kr[1] = 4'hA;
    kr[2] = 4'h5;
    kr[3] = 4'hF;
    #12;
    chk_zero();
    @(posedge clk); #1;
    reset = 1'b0;

    // SM510 full scan, flags 101
    beta = 1'b1;
    acl  = 1'b1;
    start_scan(0);
    body(0, 8, 2, 32'h0, 32'h7654_3210, 3'b101, 1'b0);
    @(posedge clk); #1;
    chk("done_width", 32'(done[0]), 32'd0);

    // SM5a scan; cpu_id moves mid-scan and a stray start pulse
    cpu_id = 4'd4;
    beta   = 1'b0;
    ba     = 1'b1;
    acl    = 1'b0;
    start_scan(0);
    cpu_id = 4'd0;
    body(0, 3, 2, 32'h7654_3210, 32'h0000_0F5A, 3'b010, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("no_extra_done", 32'(done[0]), 32'd0);
      chk("stay_idle", 32'(busy[0]), 32'd0);
    end

    // held start: back-to-back scans with one IDLE cycle
    ba = 1'b0;
    start[0] = 1'b1;
    @(posedge clk); #1;
    body(0, 8, 2, 32'h0000_0F5A, 32'h7654_3210, 3'b000, 1'b0);
    for (int i = 0; i < 8; i++) ks[i] = 4'(15 - i);
    @(posedge clk); #1;
    start[0] = 1'b0;
    body(0, 8, 2, 32'h7654_3210, 32'h89AB_CDEF, 3'b000, 1'b0);

    // settle-time extremes
    for (int i = 0; i < 8; i++) ks[i] = 4'(i);
    beta = 1'b1;
    ba   = 1'b1;
    start_scan(1);
    body(1, 8, 1, 32'h0, 32'h7654_3210, 3'b011, 1'b0);
    cpu_id = 4'd4;
    start_scan(2);
    body(2, 3, 15, 32'h0, 32'h0000_0F5A, 3'b011, 1'b0);

    // async reset mid-scan at row 4 clears every snapshot
    cpu_id = 4'd0;
    start_scan(0);
    repeat (12) begin
      @(posedge clk); #1;
    end
    chk("row4_strobe", 32'(s_o[0]), 32'h10);
    #3;
    reset = 1'b1;
    #1;
    chk_zero();
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      chk("abort_done", 32'(done[0]), 32'd0);
    end
    chk("abort_matrix", m_o[0], 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
